conv3x3_stream: RTL and testbench
=================================

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 SHALL have parameter DW, default 9: signed input pixel width.
REQ-002 SHALL have parameter KW, default 10: signed kernel coefficient width.
REQ-003 SHALL have parameter IMG_W, default 28: image width in pixels, 3..1024.
REQ-004 SHALL have parameter IMG_H, default 28: image height in rows, 3..1024.
REQ-005 SHALL have parameter OW, default 23: signed output width.
REQ-006 SHALL have parameter SHIFT, default 0: arithmetic right shift applied to the sum before saturation.
REQ-007 SHALL have parameter RELU, default 0: when 1, negative results are forced to 0.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-010 SHALL have port k_load, input, 1 bit: kernel load strobe.
REQ-011 SHALL have port k_flat, input, 9*KW bits: kernel, row-major, coefficient 0 (top-left) at the LSBs.
REQ-012 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-013 SHALL have port in_data, input, DW bits: raster-order pixel.
REQ-014 SHALL have port in_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-015 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-016 SHALL have port out_data, output, OW bits: convolution result.
REQ-017 SHALL have port out_ready, input, 1 bit: downstream accepts the output.
REQ-018 SHALL have port out_last, output, 1 bit: marks the final output of a frame.
REQ-019 SHALL have port busy, output, 1 bit: high while the FSM is in RUN.

Function
REQ-020 SHALL have FSM states IDLE and RUN; IDLE->RUN on the first accepted pixel; RUN->IDLE on the cycle after the pixel at (IMG_H-1, IMG_W-1) is accepted.
REQ-021 SHALL accept a pixel when in_valid && in_ready; in_ready = !out_valid || out_ready (single output register, no bubble).
REQ-022 SHALL latch k_flat into the kernel registers on k_load only in IDLE with no pixel accepted that cycle; k_load in RUN, or coincident with an accepted pixel, SHALL be ignored.
REQ-023 SHALL track the row/column of each accepted pixel; column wraps at IMG_W-1 (row+1), row wraps at IMG_H-1 (frame end, counters to 0).
REQ-024 SHALL keep two line buffers of IMG_W entries plus a 3x3 window register, advanced only on accepted pixels.
REQ-025 SHALL, on accepting the pixel at (r,c) with r>=2 and c>=2, register out_data = sat(relu(sum over i,j=0..2 of k[3i+j]*p[r-2+i][c-2+j] >>> SHIFT)) with out_valid=1 on the next cycle (latency 1).
REQ-026 SHALL compute products at DW+KW bits and the sum at DW+KW+4 bits, signed, with no intermediate overflow.
REQ-027 SHALL saturate to the signed OW range [-2^(OW-1), 2^(OW-1)-1] when the shifted sum exceeds it; no saturation occurs at the defaults.
REQ-028 SHALL produce exactly (IMG_H-2)*(IMG_W-2) outputs per frame (676 at the defaults); border positions produce no output.
REQ-029 SHALL hold out_valid, out_data and out_last stable while out_valid && !out_ready.
REQ-030 SHALL assert out_last with the output computed from pixel (IMG_H-1, IMG_W-1).
REQ-031 SHALL allow the next frame to follow back-to-back; the first pixel of frame N+1 may be accepted on the cycle after the last pixel of frame N, and no window data carries over.

Reset
REQ-032 SHALL, with rst==0 at a clock edge: state=IDLE, row=col=0, out_valid=0, out_data=0, out_last=0, busy=0, all kernel registers=0.
REQ-033 SHALL leave line buffer and window contents unreset; they are masked by the row/column gating.
REQ-034 SHALL, on reset mid-frame, discard any pending output and restart at pixel (0,0).

Structure
REQ-035 SHALL place the parameter defaults and the KIDX(i,j)=3i+j constant function in the shared package cnn_pkg.
REQ-036 SHALL implement each line buffer as the sub-module line_buffer (parameters DEPTH, DW; ports clk, en, din, dout), instantiated twice.

Verification
REQ-037 SHALL cover: kernel all 1, 28x28 frame of all 1 -> 676 outputs, each 9, out_last on the 676th only.
REQ-038 SHALL cover: kernel centre=1, others 0, pixel value = r*28+c mod 256 (signed 9-bit) -> out(r-1,c-1) equals the input centre pixel.
REQ-039 SHALL cover: out_ready held 0 for 10 cycles mid-frame -> in_ready=0 and out_data held; no output lost or duplicated (count 676).
REQ-040 SHALL cover: k_load with a new kernel during RUN -> ignored, outputs still use the old kernel; next frame after a load in IDLE uses the new kernel.
REQ-041 SHALL cover: RELU=1, all pixels -255, all k = 511 -> all outputs 0; RELU=0, OW=16 -> all outputs -32768 (saturated).
REQ-042 SHALL cover: rst=0 asserted at pixel 400 -> out_valid=0 next cycle; a following full frame yields a correct 676-output frame.

Source files
------------

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the streaming 3x3 convolution block:
//   - default parameter values for conv3x3_stream
//   - control FSM state encoding
//   - KIDX(i,j): row-major index of kernel coefficient (row i, column j)
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int CNN_DW    = 9;   // signed pixel width
  localparam int CNN_KW    = 10;  // signed coefficient width
  localparam int CNN_IMG_W = 28;
  localparam int CNN_IMG_H = 28;
  localparam int CNN_OW    = 23;  // signed result width
  localparam int CNN_SHIFT = 0;
  localparam int CNN_RELU  = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic int KIDX(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// Fixed-length delay line: dout presents the sample written DEPTH enables ago.
// Ports:
//   clk  - clock
//   en   - advance: write din, step the pointer
//   din  - sample in
//   dout - sample written DEPTH enables earlier (combinational read)
// -----------------------------------------------------------------------------
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_ptr;

  // Read-before-write on the same slot gives an exact DEPTH-sample delay.
  // The pointer is deliberately unreset: a circular buffer delays by DEPTH
  // whatever its phase, and stale contents are masked by row/column gating.
  assign dout = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (en) begin
      r_mem[r_ptr] <= din;
      // >= (not ==) so an out-of-range power-up value still folds back in.
      r_ptr <= (r_ptr >= AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// -----------------------------------------------------------------------------
// conv3x3_stream
// Streaming 3x3 convolution over a raster-order IMG_H x IMG_W frame. Produces
// one result per interior position (r>=2, c>=2), one cycle after the pixel
// that completes the window is accepted.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous reset, active low
//   k_load    - kernel load strobe (honoured only when idle and no pixel taken)
//   k_flat    - 9 coefficients, row-major, coefficient 0 at the LSBs
//   in_valid  - in_data valid
//   in_data   - signed pixel
//   in_ready  - pixel accepted this cycle when in_valid is high
//   out_valid - out_data valid
//   out_data  - shifted, rectified, saturated convolution result
//   out_ready - downstream accepts the output
//   out_last  - final result of a frame
//   busy      - frame in progress
// -----------------------------------------------------------------------------
module conv3x3_stream
  import cnn_pkg::*;
#(
  parameter int DW    = CNN_DW,
  parameter int KW    = CNN_KW,
  parameter int IMG_W = CNN_IMG_W,
  parameter int IMG_H = CNN_IMG_H,
  parameter int OW    = CNN_OW,
  parameter int SHIFT = CNN_SHIFT,
  parameter int RELU  = CNN_RELU
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            k_load,
  input  logic [9*KW-1:0] k_flat,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [OW-1:0]   out_data,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy
);

  localparam int PW = DW + KW;      // product width
  localparam int SW = PW + 4;       // 9-term sum width, cannot overflow
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  state_t               r_state, w_state_nxt;
  logic [RW-1:0]        r_row;
  logic [CW-1:0]        r_col;
  logic signed [KW-1:0] r_k [9];
  logic signed [DW-1:0] r_win [3][3];
  logic signed [DW-1:0] w_win_nxt [3][3];
  logic [DW-1:0]        w_lb0, w_lb1;
  logic signed [PW-1:0] w_prod [9];
  logic signed [SW-1:0] w_sum, w_shf, w_relu;
  logic [OW-1:0]        w_sat;
  logic                 w_acc, w_col_end, w_row_end, w_frame_end;
  logic                 w_out_en, w_kload;
  logic                 r_out_valid, r_out_last;
  logic [OW-1:0]        r_out_data;

  // Single output register: a new result may enter whenever the slot is
  // empty or is being drained this cycle.
  assign in_ready    = !r_out_valid || out_ready;
  assign w_acc       = in_valid && in_ready;
  assign w_col_end   = (r_col == CW'(IMG_W - 1));
  assign w_row_end   = (r_row == RW'(IMG_H - 1));
  assign w_frame_end = w_acc && w_col_end && w_row_end;
  assign w_kload     = k_load && (r_state == S_IDLE) && !w_acc;
  assign w_out_en    = w_acc && (r_row >= RW'(2)) && (r_col >= CW'(2));

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: if (w_acc) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_frame_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- kernel registers ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < 9; n++) r_k[n] <= '0;
    end else if (w_kload) begin
      for (int n = 0; n < 9; n++) r_k[n] <= $signed(k_flat[n*KW +: KW]);
    end
  end

  // ---------------- raster position ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_acc) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // ---------------- line buffers: rows r-1 and r-2 ----------------
  line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
    .clk (clk),
    .en  (w_acc),
    .din (in_data),
    .dout(w_lb0)
  );

  line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk (clk),
    .en  (w_acc),
    .din (w_lb0),
    .dout(w_lb1)
  );

  // Window after this pixel: shift left one column, new column on the right
  // (top = row r-2, middle = row r-1, bottom = incoming pixel). The MAC uses
  // this next-window so the result is registered in the accepting cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_win_nxt[i][0] = r_win[i][1];
      w_win_nxt[i][1] = r_win[i][2];
    end
    w_win_nxt[0][2] = $signed(w_lb1);
    w_win_nxt[1][2] = $signed(w_lb0);
    w_win_nxt[2][2] = $signed(in_data);
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_win <= w_win_nxt;
  end

  // ---------------- multiply-accumulate ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign w_prod[KIDX(gi, gj)] = PW'(w_win_nxt[gi][gj]) * PW'(r_k[KIDX(gi, gj)]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int n = 0; n < 9; n++) w_sum = w_sum + SW'(w_prod[n]);
  end

  assign w_shf  = w_sum >>> SHIFT;
  assign w_relu = ((RELU != 0) && (w_shf < 0)) ? '0 : w_shf;

  // ---------------- saturation to OW ----------------
  if (OW < SW) begin : g_sat
    localparam logic signed [SW-1:0] MAXV = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    always_comb begin
      if (w_relu > MAXV)      w_sat = MAXV[OW-1:0];
      else if (w_relu < MINV) w_sat = MINV[OW-1:0];
      else                    w_sat = w_relu[OW-1:0];
    end
  end else if (OW == SW) begin : g_eq
    assign w_sat = w_relu;
  end else begin : g_ext
    assign w_sat = {{(OW-SW){w_relu[SW-1]}}, w_relu};
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (in_ready) begin
      r_out_valid <= w_out_en;
      if (w_out_en) begin
        r_out_data <= w_sat;
        r_out_last <= w_frame_end;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// -----------------------------------------------------------------------------
// tb_conv3x3_stream
// Scoreboard bench: the stimulus pushes the expected result for every pixel
// that completes a window; a negedge monitor pops and compares whatever the
// DUTs present. Three instances: defaults, RELU=1, OW=16 (the latter two only
// see pixels during the saturation frame).
// -----------------------------------------------------------------------------
module tb_conv3x3_stream;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NOUT = (H - 2) * (W - 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, k_load, in_valid, out_ready, sat_en;
  logic [89:0] k_flat;
  logic [8:0]  in_data;
  logic        iv12;
  assign iv12 = in_valid & sat_en;

  logic ir0, ov0, ol0, bz0;  logic [22:0] od0;
  logic ir1, ov1, ol1, bz1;  logic [22:0] od1;
  logic ir2, ov2, ol2, bz2;  logic [15:0] od2;

  conv3x3_stream u_dut0 (
    .clk(clk), .rst(rst), .k_load(k_load), .k_flat(k_flat),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
    .out_last(ol0), .busy(bz0));

  conv3x3_stream #(.RELU(1)) u_dut1 (
    .clk(clk), .rst(rst), .k_load(k_load), .k_flat(k_flat),
    .in_valid(iv12), .in_data(in_data), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
    .out_last(ol1), .busy(bz1));

  conv3x3_stream #(.OW(16)) u_dut2 (
    .clk(clk), .rst(rst), .k_load(k_load), .k_flat(k_flat),
    .in_valid(iv12), .in_data(in_data), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_ready(out_ready),
    .out_last(ol2), .busy(bz2));

  typedef struct {int v; bit last;} exp_t;
  exp_t q0[$], q1[$], q2[$];
  exp_t me;
  int   pix [H][W];
  int   kern [9];
  int   total = 0, bad = 0, cnt0 = 0;
  bit   hold_prev = 1'b0;
  int   prev0 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: direct 3x3 sum over the stored frame, then ReLU and clamp.
  function automatic int ref_out(input int r, input int c, input bit relu, input int ow);
    longint s, mx, mn;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += longint'(kern[3*i+j]) * longint'(pix[r-2+i][c-2+j]);
    if (relu && s < 0) s = 0;
    mx = (64'sd1 <<< (ow - 1)) - 1;
    mn = -(64'sd1 <<< (ow - 1));
    if (s > mx) s = mx;
    if (s < mn) s = mn;
    return int'(s);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (hold_prev) begin
        chk("hold_valid", int'(ov0), 1);
        chk("hold_data", int'($signed(od0)), prev0);
      end
      hold_prev = ov0 && !out_ready;
      prev0     = int'($signed(od0));
      if (ov0 && !out_ready) chk("in_ready_stall", int'(ir0), 0);
      if (ov0 && out_ready) begin
        if (q0.size() == 0) chk("unexpected_out0", 1, 0);
        else begin
          me = q0.pop_front();
          chk("out0", int'($signed(od0)), me.v);
          chk("last0", int'(ol0), int'(me.last));
          cnt0++;
        end
      end
      if (ov1 && out_ready) begin
        if (q1.size() == 0) chk("unexpected_out1", 1, 0);
        else begin
          me = q1.pop_front();
          chk("out1_relu", int'($signed(od1)), me.v);
        end
      end
      if (ov2 && out_ready) begin
        if (q2.size() == 0) chk("unexpected_out2", 1, 0);
        else begin
          me = q2.pop_front();
          chk("out2_sat", int'($signed(od2)), me.v);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Tasks are entered and left 1 time unit after a rising edge.
  task automatic load_k(input int k [9]);
    int tmp;
    for (int n = 0; n < 9; n++) begin
      tmp = k[n];
      k_flat[n*10 +: 10] = tmp[9:0];
    end
    in_valid = 1'b0;
    k_load   = 1'b1;
    @(posedge clk); #1;
    k_load = 1'b0;
    kern   = k;
  endtask

  // pat: 0 all ones, 1 ramp (r*W+c) mod 256, 2 all -255.
  // exp_cnt 0 leaves the frame undrained so the next one follows back-to-back.
  task automatic run_frame(input int pat, input int stall_at, input int kl_at,
                           input int rst_at, input bit sat, input int exp_cnt);
    int   idx, cyc, stall_left, r, c;
    bit   acc, stalled;
    exp_t e;
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++)
        pix[rr][cc] = (pat == 0) ? 1 : (pat == 1) ? ((rr * W + cc) % 256) : -255;
    sat_en = sat; idx = 0; cyc = 0; stall_left = 0; stalled = 1'b0;
    while (idx < H * W && cyc < 5000) begin
      r = idx / W;
      c = idx % W;
      in_valid = 1'b1;
      in_data  = 9'(pix[r][c]);
      if (idx == stall_at && !stalled) begin
        stalled    = 1'b1;
        stall_left = 10;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (idx == kl_at) begin
        k_load = 1'b1;
        k_flat = {9{10'd1}};
      end else k_load = 1'b0;
      @(negedge clk);
      if (idx == stall_at && stall_left == 9) chk("busy_run", int'(bz0), 1);
      acc = ir0;
      if (acc && r >= 2 && c >= 2) begin
        e.v = ref_out(r, c, 1'b0, 23);
        e.last = (idx == H * W - 1);
        q0.push_back(e);
        if (sat) begin
          e.v = ref_out(r, c, 1'b1, 23); q1.push_back(e);
          e.v = ref_out(r, c, 1'b0, 16); q2.push_back(e);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      if (rst_at >= 0 && idx == rst_at) begin
        in_valid = 1'b0; k_load = 1'b0; out_ready = 1'b1; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_out_data", int'(od0), 0);
        chk("rst_busy", int'(bz0), 0);
        q0.delete(); q1.delete(); q2.delete();
        cnt0 = 0; hold_prev = 1'b0;
        kern = '{default: 0};
        @(posedge clk); #1;
        sat_en = 1'b0;
        return;
      end
    end
    in_valid = 1'b0; k_load = 1'b0; out_ready = 1'b1;
    if (idx < H * W) chk("frame_timeout", idx, H * W);
    if (exp_cnt > 0) begin
      for (int t = 0; t < 50 && (q0.size() + q1.size() + q2.size()) > 0; t++) begin
        @(posedge clk); #1;
      end
      chk("frame_count", cnt0, exp_cnt);
      chk("queue_drain", q0.size() + q1.size() + q2.size(), 0);
      chk("busy_idle", int'(bz0), 0);
      cnt0 = 0;
    end
    sat_en = 1'b0;
  endtask

  initial begin
    int k_one [9], k_ctr [9], k_mix [9], k_sat [9];
    k_one = '{default: 1};
    k_ctr = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    k_mix = '{1, -2, 3, -4, 5, -6, 7, -8, 9};
    k_sat = '{default: 511};
    kern  = '{default: 0};
    rst = 1'b0; k_load = 1'b0; in_valid = 1'b0; in_data = '0;
    k_flat = '0; out_ready = 1'b1; sat_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(ov0), 0);
    chk("reset_out_data", int'(od0), 0);
    chk("reset_out_last", int'(ol0), 0);
    chk("reset_busy", int'(bz0), 0);
    chk("reset_in_ready", int'(ir0), 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // all-ones kernel and frame: every result 9, last flag on the final one
    load_k(k_one);
    run_frame(0, -1, -1, -1, 1'b0, NOUT);
    // centre kernel on a ramp, two frames back-to-back; the second one has a
    // 10-cycle downstream stall and an ignored k_load during RUN
    load_k(k_ctr);
    run_frame(1, -1, -1, -1, 1'b0, 0);
    run_frame(1, 300, 300, -1, 1'b0, 2 * NOUT);
    // kernel loaded in IDLE takes effect on the next frame
    load_k(k_mix);
    run_frame(1, -1, -1, -1, 1'b0, NOUT);
    // large negative sums: ReLU clamps to 0, OW=16 saturates to -32768
    load_k(k_sat);
    run_frame(2, -1, -1, -1, 1'b1, NOUT);
    // reset after 400 pixels, then full frames: kernel cleared, then reloaded
    run_frame(1, -1, -1, 400, 1'b0, 0);
    run_frame(1, -1, -1, -1, 1'b0, NOUT);
    load_k(k_ctr);
    run_frame(1, -1, -1, -1, 1'b0, NOUT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
